// File: rtl/program_loader_pkg.sv
// Shared definitions for the SAP program loader: FSM state encoding,
// word framing constants and the opcode/operand byte lanes.
package program_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE  = 3'd0,
        LDR_COUNT = 3'd1,
        LDR_HI    = 3'd2,
        LDR_LO    = 3'd3,
        LDR_WRITE = 3'd4,
        LDR_CHK   = 3'd5,
        LDR_DONE  = 3'd6,
        LDR_ERROR = 3'd7
    } ldr_state_e;

    localparam int SAP_WORD_BYTES  = 2;
    localparam int SAP_OPCODE_MSB  = 15;
    localparam int SAP_OPCODE_LSB  = 8;
    localparam int SAP_OPERAND_MSB = 7;
    localparam int SAP_OPERAND_LSB = 0;

    // States in which the loader is willing to take a stream byte
    function automatic logic is_rx_state(input ldr_state_e s);
        return (s == LDR_COUNT) || (s == LDR_HI) || (s == LDR_LO) || (s == LDR_CHK);
    endfunction

endpackage

// File: rtl/program_loader_checksum.sv
// 8-bit running sum over the count byte and every data byte of a load.
// Only present when PROG_CHECKSUM_EN is defined; without it the loader
// has no trailer check and this module is not built.
`ifdef PROG_CHECKSUM_EN
module program_loader_checksum (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_add,
    input  logic [7:0] i_byte,
    output logic [7:0] o_sum
);

    logic [7:0] sum_q;

    // Clear at the start of a load, otherwise accumulate accepted bytes
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sum_q <= 8'd0;
        end else if (i_clear) begin
            sum_q <= 8'd0;
        end else if (i_add) begin
            sum_q <= sum_q + i_byte;
        end
    end

    assign o_sum = sum_q;

endmodule
`endif

// File: rtl/program_loader.sv
// SAP program loader: frames a valid/ready byte stream (count N, then N
// high/low byte pairs) into 16-bit words and writes them into the RAM
// program port, holding the CPU in reset while loading.
// Optional trailer checksum is enabled by defining PROG_CHECKSUM_EN.
//
// state     | meaning
// IDLE      | waiting for i_start after reset
// COUNT     | taking the word count byte (0 means a full RAM)
// HI        | taking the opcode byte of the next word
// LO        | taking the operand byte of the next word
// WRITE     | one-cycle RAM write strobe, address/data stable
// CHK       | taking the checksum trailer byte
// DONE      | load complete, CPU released
// ERROR     | checksum mismatch, CPU still held in reset
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_program_mode,
    output logic [ADDR_WIDTH-1:0] o_program_address,
    output logic [DATA_WIDTH-1:0] o_program_data,
    output logic                  o_write_enable,
    output logic                  o_cpu_reset,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

    ldr_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic [ADDR_WIDTH:0]       remaining_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      ready_q, busy_q, done_q, cpu_reset_q, we_q;
    logic                      accept;
    logic                      start_load;
    logic                      add_byte;

    assign accept     = i_byte_valid & ready_q;
    assign start_load = i_start & ((state_q == LDR_IDLE) || (state_q == LDR_DONE) ||
                                   (state_q == LDR_ERROR));
    assign add_byte   = accept & ((state_q == LDR_COUNT) || (state_q == LDR_HI) ||
                                  (state_q == LDR_LO));

`ifdef PROG_CHECKSUM_EN
    logic [7:0] sum;
    logic       error_q;

    program_loader_checksum u_checksum (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (start_load),
        .i_add   (add_byte),
        .i_byte  (i_byte),
        .o_sum   (sum)
    );
`else
    logic unused_add;
    assign unused_add = add_byte;
`endif

    // Next-state decode; outputs are registered from state_d below
    always_comb begin
        state_d = state_q;
        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERROR: if (i_start) state_d = LDR_COUNT;
            LDR_COUNT: if (accept) state_d = LDR_HI;
            LDR_HI:    if (accept) state_d = LDR_LO;
            LDR_LO:    if (accept) state_d = LDR_WRITE;
            LDR_WRITE: begin
                if (remaining_q == CNT_ONE) begin
`ifdef PROG_CHECKSUM_EN
                    state_d = LDR_CHK;
`else
                    state_d = LDR_DONE;
`endif
                end else begin
                    state_d = LDR_HI;
                end
            end
`ifdef PROG_CHECKSUM_EN
            LDR_CHK: if (accept) state_d = (i_byte == sum) ? LDR_DONE : LDR_ERROR;
`endif
            default: state_d = LDR_IDLE;
        endcase
    end

    // State register, registered status outputs, counters and data latch
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= LDR_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cpu_reset_q <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= is_rx_state(state_d);
            busy_q      <= is_rx_state(state_d) || (state_d == LDR_WRITE);
            done_q      <= (state_d == LDR_DONE);
            cpu_reset_q <= is_rx_state(state_d) || (state_d == LDR_WRITE) ||
                           (state_d == LDR_ERROR);
            we_q        <= (state_d == LDR_WRITE);

            if (start_load) begin
                addr_q <= '0;
            end
            case (state_q)
                LDR_COUNT: if (accept) begin
                    remaining_q <= (i_byte == 8'd0) ? CNT_FULL : (ADDR_WIDTH+1)'(i_byte);
                end
                LDR_HI: if (accept) data_q[SAP_OPCODE_MSB:SAP_OPCODE_LSB] <= i_byte;
                LDR_LO: if (accept) data_q[SAP_OPERAND_MSB:SAP_OPERAND_LSB] <= i_byte;
                LDR_WRITE: begin
                    addr_q      <= addr_q + ADDR_WIDTH'(1);
                    remaining_q <= remaining_q - CNT_ONE;
                end
                default: ;
            endcase
        end
    end

`ifdef PROG_CHECKSUM_EN
    // Error flag follows the ERROR state
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= (state_d == LDR_ERROR);
        end
    end

    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    assign o_byte_ready      = ready_q;
    assign o_program_mode    = busy_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_cpu_reset       = cpu_reset_q;
    assign o_write_enable    = we_q;
    assign o_program_address = addr_q;
    assign o_program_data    = data_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader. Builds with or without PROG_CHECKSUM_EN;
// with it defined every load is followed by a bench-computed trailer byte.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_start;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_byte_ready;
    logic        o_program_mode;
    logic [7:0]  o_program_address;
    logic [15:0] o_program_data;
    logic        o_write_enable;
    logic        o_cpu_reset;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [256];
    logic [7:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];

    program_loader #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .i_clock           (clk),
        .i_reset           (rst),
        .i_start           (i_start),
        .i_byte_valid      (i_byte_valid),
        .i_byte            (i_byte),
        .o_byte_ready      (o_byte_ready),
        .o_program_mode    (o_program_mode),
        .o_program_address (o_program_address),
        .o_program_data    (o_program_data),
        .o_write_enable    (o_write_enable),
        .o_cpu_reset       (o_cpu_reset),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_error           (o_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_write_enable) begin
            wr_addr_q.push_back(o_program_address);
            wr_data_q.push_back(o_program_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        i_byte_valid = 1'b1;
        i_byte = b;
        while (!o_byte_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("send_timeout", 32'(k < 100), 32'd1);
        @(negedge clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic start_load();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!o_done && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("done_timeout", 32'(k < 3000), 32'd1);
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    // Count byte, n word pairs, optional trailer; optional i_start poke after word 'poke'
    task automatic load_words(input int n, input int poke);
        logic [7:0] sum;
        logic [7:0] nb;
        nb  = 8'(n);
        sum = nb;
        send_byte(nb);
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8]);
            sum = sum + words[i][15:8];
            send_byte(words[i][7:0]);
            sum = sum + words[i][7:0];
            check("wr_latency", 32'(o_write_enable), 32'd1);
            if (i == poke) begin
                i_start = 1'b1;
                @(negedge clk);
                i_start = 1'b0;
            end
        end
`ifdef PROG_CHECKSUM_EN
        send_byte(sum);
`endif
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  32'(o_busy), 32'd0);
        check({tag, "_done"},  32'(o_done), 32'd0);
        check({tag, "_err"},   32'(o_error), 32'd0);
        check({tag, "_cpur"},  32'(o_cpu_reset), 32'd0);
        check({tag, "_mode"},  32'(o_program_mode), 32'd0);
        check({tag, "_we"},    32'(o_write_enable), 32'd0);
        check({tag, "_rdy"},   32'(o_byte_ready), 32'd0);
        check({tag, "_addr"},  32'(o_program_address), 32'd0);
        check({tag, "_data"},  32'(o_program_data), 32'd0);
    endtask

    initial begin
        logic [7:0] b;
        rst = 1'b1;
        i_start = 1'b0;
        i_byte_valid = 1'b0;
        i_byte = 8'h00;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Four-word load at addresses 0..3
        words[0] = 16'h00FF; words[1] = 16'h017F; words[2] = 16'h0201; words[3] = 16'h0702;
        clear_writes();
        start_load();
        check("t1_busy", 32'(o_busy), 32'd1);
        check("t1_mode", 32'(o_program_mode), 32'd1);
        check("t1_cpur", 32'(o_cpu_reset), 32'd1);
        check("t1_rdy",  32'(o_byte_ready), 32'd1);
        load_words(4, -1);
        wait_done();
        check("t1_nwr", 32'(wr_addr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check("t1_addr", 32'(wr_addr_q[i]), 32'(i));
            check("t1_data", 32'(wr_data_q[i]), 32'(words[i]));
        end
        check("t1_done", 32'(o_done), 32'd1);
        check("t1_cpur_end", 32'(o_cpu_reset), 32'd0);
        check("t1_mode_end", 32'(o_program_mode), 32'd0);
        check("t1_busy_end", 32'(o_busy), 32'd0);
        check("t1_rdy_end",  32'(o_byte_ready), 32'd0);

        // Stall between HI and LO
        clear_writes();
        start_load();
        send_byte(8'h01);
        send_byte(8'hAB);
        for (int i = 0; i < 5; i++) begin
            check("t2_no_we", 32'(o_write_enable), 32'd0);
            check("t2_hi_hold", 32'(o_program_data[15:8]), 32'hAB);
            @(negedge clk);
        end
        send_byte(8'hCD);
        check("t2_we", 32'(o_write_enable), 32'd1);
        check("t2_data", 32'(o_program_data), 32'hABCD);
        check("t2_addr", 32'(o_program_address), 32'd0);
`ifdef PROG_CHECKSUM_EN
        send_byte(8'h01 + 8'hAB + 8'hCD);
`endif
        wait_done();

        // i_start pulsed mid-load is ignored
        words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
        clear_writes();
        start_load();
        load_words(4, 1);
        wait_done();
        check("t3_nwr", 32'(wr_addr_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
            check("t3_addr", 32'(wr_addr_q[i]), 32'(i));
            check("t3_data", 32'(wr_data_q[i]), 32'(words[i]));
        end

        // Reset after two words of a four-word load
        clear_writes();
        start_load();
        send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        @(negedge clk);
        check("t4_nwr_pre", 32'(wr_addr_q.size()), 32'd2);
        rst = 1'b1;
        #1;
        check_all_zero("t4_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_writes();
        words[0] = 16'h1234;
        start_load();
        load_words(1, -1);
        wait_done();
        check("t4_nwr", 32'(wr_addr_q.size()), 32'd1);
        if (wr_addr_q.size() > 0) begin
            check("t4_addr", 32'(wr_addr_q[0]), 32'd0);
            check("t4_data", 32'(wr_data_q[0]), 32'h1234);
        end

        // N=0 means 256 words; address wraps back to 0
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            words[i] = {b, ~b};
        end
        clear_writes();
        start_load();
        load_words(256, -1);
        wait_done();
        check("t5_nwr", 32'(wr_addr_q.size()), 32'd256);
        for (int i = 0; i < 256 && i < wr_addr_q.size(); i++) begin
            check("t5_addr", 32'(wr_addr_q[i]), 32'(i));
            check("t5_data", 32'(wr_data_q[i]), 32'(words[i]));
        end
        check("t5_wrap", 32'(o_program_address), 32'd0);
        check("t5_done", 32'(o_done), 32'd1);

`ifdef PROG_CHECKSUM_EN
        // Trailer checks: 01 + 01 + 7F = 81
        start_load();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h7F);
        send_byte(8'h81);
        wait_done();
        check("t6_ok_done", 32'(o_done), 32'd1);
        check("t6_ok_err",  32'(o_error), 32'd0);
        start_load();
        send_byte(8'h01); send_byte(8'h01); send_byte(8'h7F);
        send_byte(8'h80);
        begin
            int k;
            k = 0;
            while (!o_error && k < 100) begin
                @(negedge clk);
                k++;
            end
            check("t6_err_timeout", 32'(k < 100), 32'd1);
        end
        check("t6_err",  32'(o_error), 32'd1);
        check("t6_cpur", 32'(o_cpu_reset), 32'd1);
        check("t6_mode", 32'(o_program_mode), 32'd0);
        check("t6_busy", 32'(o_busy), 32'd0);
        check("t6_done", 32'(o_done), 32'd0);
        start_load();
        check("t6_restart_busy", 32'(o_busy), 32'd1);
        check("t6_restart_rdy",  32'(o_byte_ready), 32'd1);
        check("t6_restart_err",  32'(o_error), 32'd0);
`else
        check("t6_no_error", 32'(o_error), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
